// File: rtl/hy_multi_timer.sv
// Multi-channel reload down-counter timer with one-shot/periodic modes and sticky W1C interrupts.
// Optional shared prescaler enabled by defining HY_TIMER_PRESCALE_EN (adds the prescale port).
module hy_multi_timer #(
  parameter int unsigned C_WIDTH   = 32,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CH_AW     = 2,
  parameter int unsigned PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [CH_AW-1:0]     cfg_ch,
  input  logic [C_WIDTH-1:0]   cfg_reload,
  input  logic                 cfg_mode,
  input  logic                 cfg_start,
  input  logic [N_CH-1:0]      stop,
  input  logic [N_CH-1:0]      int_clr,
  input  logic [N_CH-1:0]      int_mask,
  input  logic [CH_AW-1:0]     rd_ch,
`ifdef HY_TIMER_PRESCALE_EN
  input  logic [PRE_WIDTH-1:0] prescale,
`endif
  output logic [C_WIDTH-1:0]   rd_cnt,
  output logic [N_CH-1:0]      run,
  output logic [N_CH-1:0]      int_pend,
  output logic                 int_o
);

  if (N_CH < 1 || N_CH > 16 || N_CH > (1 << CH_AW) || PRE_WIDTH == 0) begin : g_bad_params
    $error("hy_multi_timer: invalid parameter combination");
  end

  typedef enum logic [0:0] {StIdle, StRun} ch_state_e;

  ch_state_e          state_q  [N_CH];
  ch_state_e          state_d  [N_CH];
  logic [C_WIDTH-1:0] count_q  [N_CH];
  logic [C_WIDTH-1:0] count_d  [N_CH];
  logic [C_WIDTH-1:0] reload_q [N_CH];
  logic [C_WIDTH-1:0] reload_d [N_CH];
  logic [N_CH-1:0]    mode_q, mode_d;
  logic [N_CH-1:0]    pend_q, pend_d;
  logic [N_CH-1:0]    evt;
  logic               int_o_q;
  logic               tick;

`ifdef HY_TIMER_PRESCALE_EN
  logic [PRE_WIDTH-1:0] pre_q, pre_d;

  // >= rather than == so a prescale lowered below the current count still wraps promptly.
  always_comb begin
    tick  = (pre_q >= prescale);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    evt = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      state_d[k]  = state_q[k];
      count_d[k]  = count_q[k];
      reload_d[k] = reload_q[k];
      mode_d[k]   = mode_q[k];

      if (state_q[k] == StRun && tick) begin
        if (count_q[k] != '0) begin
          count_d[k] = count_q[k] - 1'b1;
        end else begin
          evt[k] = 1'b1;
          if (mode_q[k]) begin
            count_d[k] = reload_q[k];
          end else begin
            state_d[k] = StIdle;
          end
        end
      end

      // Stop freezes the count as it was; a config write overrides both stop and counting.
      if (stop[k]) begin
        state_d[k] = StIdle;
        count_d[k] = count_q[k];
      end

      if (cfg_we && cfg_ch == CH_AW'(k)) begin
        reload_d[k] = cfg_reload;
        count_d[k]  = cfg_reload;
        mode_d[k]   = cfg_mode;
        state_d[k]  = cfg_start ? StRun : StIdle;
      end
    end

    pend_d = (pend_q & ~int_clr) | evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '{default: StIdle};
      count_q  <= '{default: '0};
      reload_q <= '{default: '0};
      mode_q   <= '0;
      pend_q   <= '0;
      int_o_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      int_o_q  <= |(pend_d & int_mask);
    end
  end

  always_comb begin
    rd_cnt = '0;
    run    = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      run[k] = (state_q[k] == StRun);
      if (rd_ch == CH_AW'(k)) begin
        rd_cnt = count_q[k];
      end
    end
  end

  assign int_pend = pend_q;
  assign int_o    = int_o_q;

endmodule

// File: tb/tb_hy_multi_timer.sv
// Self-checking bench for hy_multi_timer: directed scenarios plus randomized traffic against a
// behavioural model. A second 3-channel instance covers out-of-range channel addresses.
module tb_hy_multi_timer;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int AW  = 2;
  localparam int PW  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_we = 1'b0;
  logic [AW-1:0]  cfg_ch = '0;
  logic [CW-1:0]  cfg_reload = '0;
  logic           cfg_mode = 1'b0;
  logic           cfg_start = 1'b0;
  logic [NCH-1:0] stop = '0;
  logic [NCH-1:0] int_clr = '0;
  logic [NCH-1:0] int_mask = '0;
  logic [AW-1:0]  rd_ch = '0;
`ifdef HY_TIMER_PRESCALE_EN
  logic [PW-1:0]  prescale = '0;
`endif
  logic [CW-1:0]  rd_cnt, rd_cnt2;
  logic [NCH-1:0] run, int_pend;
  logic [2:0]     run2, pend2;
  logic           int_o, int_o2;

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural model state
  longint unsigned m_cnt[NCH];
  longint unsigned m_rel[NCH];
  logic [NCH-1:0]  m_mode, m_run, m_pend;
  logic            m_into, m_into2;
  int              m_pre;

  always #5 clk = ~clk;

  hy_multi_timer #(.C_WIDTH(CW), .N_CH(NCH), .CH_AW(AW), .PRE_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_reload(cfg_reload),
    .cfg_mode(cfg_mode), .cfg_start(cfg_start), .stop(stop), .int_clr(int_clr),
    .int_mask(int_mask), .rd_ch(rd_ch),
`ifdef HY_TIMER_PRESCALE_EN
    .prescale(prescale),
`endif
    .rd_cnt(rd_cnt), .run(run), .int_pend(int_pend), .int_o(int_o)
  );

  hy_multi_timer #(.C_WIDTH(CW), .N_CH(3), .CH_AW(AW), .PRE_WIDTH(PW)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_reload(cfg_reload),
    .cfg_mode(cfg_mode), .cfg_start(cfg_start), .stop(stop[2:0]), .int_clr(int_clr[2:0]),
    .int_mask(int_mask[2:0]), .rd_ch(rd_ch),
`ifdef HY_TIMER_PRESCALE_EN
    .prescale(prescale),
`endif
    .rd_cnt(rd_cnt2), .run(run2), .int_pend(pend2), .int_o(int_o2)
  );

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_cnt[k] = 0;
      m_rel[k] = 0;
    end
    m_mode = '0; m_run = '0; m_pend = '0; m_into = 1'b0; m_into2 = 1'b0; m_pre = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit tick;
    logic [NCH-1:0] ev;
    tick = 1'b1;
    ev = '0;
`ifdef HY_TIMER_PRESCALE_EN
    tick = (m_pre >= int'(prescale));
    m_pre = tick ? 0 : m_pre + 1;
`endif
    for (int k = 0; k < NCH; k++) begin
      ev[k] = m_run[k] && tick && (m_cnt[k] == 0);
      if (cfg_we && int'(cfg_ch) == k) begin
        m_rel[k] = cfg_reload; m_cnt[k] = cfg_reload; m_mode[k] = cfg_mode; m_run[k] = cfg_start;
      end else if (stop[k]) begin
        m_run[k] = 1'b0;
      end else if (m_run[k] && tick) begin
        if (m_cnt[k] != 0) m_cnt[k] = m_cnt[k] - 1;
        else if (m_mode[k]) m_cnt[k] = m_rel[k];
        else m_run[k] = 1'b0;
      end
    end
    m_pend = (m_pend & ~int_clr) | ev;
    m_into = |(m_pend & int_mask);
    m_into2 = |(m_pend[2:0] & int_mask[2:0]);
  endtask

  function automatic logic [CW-1:0] exp_rd(input int n);
    if (int'(rd_ch) < n) return CW'(m_cnt[rd_ch]);
    return '0;
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cfg_we = 1'b0; stop = '0; int_clr = '0;
  endtask

  task automatic set_cfg(input int ch, input longint unsigned rel, input bit mode, input bit st);
    cfg_we = 1'b1; cfg_ch = AW'(ch); cfg_reload = CW'(rel); cfg_mode = mode; cfg_start = st;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cfg_we = 1'b0; stop = '0; int_clr = '0; int_mask = '0; rd_ch = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < NCH; k++) begin
      rd_ch = AW'(k);
      #1;
      n_checks++;
      if (rd_cnt !== '0) begin
        n_fail++; $display("FAIL reset_rd_cnt ch%0d: got %0h want 0", k, rd_cnt);
      end
    end
    n_checks++;
    if (run !== '0 || int_pend !== '0 || int_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got run=%b pend=%b int_o=%b want 0", run, int_pend, int_o);
    end
  endtask

  task automatic test_periodic();
    bit exp_p;
    do_reset();
    int_mask = 4'b0001; rd_ch = 0;
    set_cfg(0, 3, 1'b1, 1'b1);
    cycle();
    for (int e = 1; e <= 12; e++) begin
      if (e == 6) int_clr[0] = 1'b1;
      cycle();
      exp_p = (e >= 4 && e < 6) || (e >= 8);
      n_checks++;
      if (int_pend[0] !== exp_p || int_o !== exp_p) begin
        n_fail++; $display("FAIL periodic_pend e=%0d: got pend=%b int_o=%b want %b", e, int_pend[0], int_o, exp_p);
      end
      n_checks++;
      if (rd_cnt !== CW'(3 - (e % 4))) begin
        n_fail++; $display("FAIL periodic_cnt e=%0d: got %0d want %0d", e, rd_cnt, 3 - (e % 4));
      end
    end
  endtask

  task automatic test_one_shot();
    do_reset();
    int_mask = 4'b0010; rd_ch = 1;
    set_cfg(1, 5, 1'b0, 1'b1);
    cycle();
    for (int e = 1; e <= 26; e++) begin
      cycle();
      n_checks++;
      if (int_pend[1] !== (e >= 6) || run[1] !== (e < 6)) begin
        n_fail++; $display("FAIL oneshot_state e=%0d: got pend=%b run=%b want %b %b", e, int_pend[1], run[1], e >= 6, e < 6);
      end
      n_checks++;
      if (rd_cnt !== ((e <= 5) ? CW'(5 - e) : '0)) begin
        n_fail++; $display("FAIL oneshot_cnt e=%0d: got %0d want %0d", e, rd_cnt, (e <= 5) ? 5 - e : 0);
      end
    end
  endtask

  task automatic test_all_channels();
    do_reset();
    int_mask = 4'b1011;
    for (int k = 0; k < NCH; k++) begin
      set_cfg(k, k + 1, 1'b1, 1'b1);
      cycle();
    end
    for (int i = 0; i < 24; i++) begin
      rd_ch = AW'(i % NCH);
      int_clr = ($urandom % 3 == 0) ? NCH'($urandom) : '0;
      cycle();
      n_checks++;
      if (int_pend !== m_pend || int_o !== m_into || run !== m_run || rd_cnt !== exp_rd(NCH)) begin
        n_fail++; $display("FAIL allch_model i=%0d: got pend=%b int_o=%b cnt=%0d want pend=%b int_o=%b cnt=%0d", i, int_pend, int_o, rd_cnt, m_pend, m_into, exp_rd(NCH));
      end
    end
    stop = 4'b1011; int_clr = '1;
    cycle();
    int_clr = '1;
    cycle();
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (int_pend[2] !== 1'b1 || (int_pend & 4'b1011) !== '0 || int_o !== 1'b0) begin
      n_fail++; $display("FAIL allch_masked: got pend=%b int_o=%b want pend=0100 int_o=0", int_pend, int_o);
    end
  endtask

  task automatic test_stop();
    do_reset();
    int_mask = 4'b0100; rd_ch = 2;
    set_cfg(2, 20, 1'b1, 1'b1);
    cycle();
    for (int e = 1; e <= 13; e++) cycle();
    n_checks++;
    if (rd_cnt !== CW'(7)) begin
      n_fail++; $display("FAIL stop_precount: got %0d want 7", rd_cnt);
    end
    stop[2] = 1'b1;
    cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_checks++;
      if (rd_cnt !== CW'(7) || run[2] !== 1'b0) begin
        n_fail++; $display("FAIL stop_frozen i=%0d: got cnt=%0d run=%b want 7 0", i, rd_cnt, run[2]);
      end
    end
    set_cfg(2, 2, 1'b1, 1'b1);
    cycle();
    for (int e = 1; e <= 3; e++) begin
      cycle();
      n_checks++;
      if (int_pend[2] !== (e == 3) || int_o !== (e == 3) || rd_cnt !== CW'((e == 3) ? 2 : 2 - e)) begin
        n_fail++; $display("FAIL stop_restart e=%0d: got pend=%b int_o=%b cnt=%0d", e, int_pend[2], int_o, rd_cnt);
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    int_mask = 4'b0001; rd_ch = 0;
    set_cfg(0, 1, 1'b1, 1'b1);
    cycle();
    cycle();
    cycle();
    n_checks++;
    if (int_pend[0] !== 1'b1) begin
      n_fail++; $display("FAIL cont_first_event: got %b want 1", int_pend[0]);
    end
    int_clr[0] = 1'b1;
    cycle();
    n_checks++;
    if (int_pend[0] !== 1'b0) begin
      n_fail++; $display("FAIL cont_clear: got %b want 0", int_pend[0]);
    end
    int_clr[0] = 1'b1;
    cycle();
    n_checks++;
    if (int_pend[0] !== 1'b1 || int_o !== 1'b1) begin
      n_fail++; $display("FAIL cont_event_beats_clr: got pend=%b int_o=%b want 1 1", int_pend[0], int_o);
    end
    set_cfg(1, 9, 1'b1, 1'b1);
    stop[1] = 1'b1; rd_ch = 1;
    cycle();
    n_checks++;
    if (run[1] !== 1'b1 || rd_cnt !== CW'(9)) begin
      n_fail++; $display("FAIL cont_cfg_beats_stop: got run=%b cnt=%0d want 1 9", run[1], rd_cnt);
    end
    cycle();
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (run !== '0 || int_pend !== '0 || int_o !== 1'b0 || rd_cnt !== '0) begin
      n_fail++; $display("FAIL cont_async_reset: got run=%b pend=%b int_o=%b cnt=%0d want 0", run, int_pend, int_o, rd_cnt);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_out_of_range();
    do_reset();
    set_cfg(3, 9, 1'b1, 1'b1);
    cycle();
    rd_ch = 3;
    #1;
    n_checks++;
    if (run2 !== 3'b000 || rd_cnt2 !== '0) begin
      n_fail++; $display("FAIL oob_write_ignored: got run=%b cnt=%0d want 000 0", run2, rd_cnt2);
    end
    n_checks++;
    if (run[3] !== 1'b1 || rd_cnt !== CW'(9)) begin
      n_fail++; $display("FAIL oob_ch3_main: got run=%b cnt=%0d want 1 9", run[3], rd_cnt);
    end
    set_cfg(2, 9, 1'b0, 1'b0);
    cycle();
    rd_ch = 2;
    #1;
    n_checks++;
    if (rd_cnt2 !== CW'(9) || run2 !== 3'b000) begin
      n_fail++; $display("FAIL oob_inrange_load: got cnt=%0d run=%b want 9 000", rd_cnt2, run2);
    end
  endtask

  task automatic test_random();
    do_reset();
`ifdef HY_TIMER_PRESCALE_EN
    prescale = PW'($urandom_range(0, 3));
`endif
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 6 == 0) begin
        set_cfg($urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom), ($urandom % 4) != 0);
      end
      stop = ($urandom % 8 == 0) ? NCH'($urandom) : '0;
      int_clr = ($urandom % 4 == 0) ? NCH'($urandom) : '0;
      if (i % 16 == 0) int_mask = NCH'($urandom);
      rd_ch = AW'($urandom);
      cycle();
      n_checks++;
      if (run !== m_run || int_pend !== m_pend || int_o !== m_into) begin
        n_fail++; $display("FAIL rand_state i=%0d: got run=%b pend=%b int_o=%b want %b %b %b", i, run, int_pend, int_o, m_run, m_pend, m_into);
      end
      n_checks++;
      if (rd_cnt !== exp_rd(NCH)) begin
        n_fail++; $display("FAIL rand_rd_cnt i=%0d ch=%0d: got %0d want %0d", i, rd_ch, rd_cnt, exp_rd(NCH));
      end
      n_checks++;
      if (run2 !== m_run[2:0] || pend2 !== m_pend[2:0] || int_o2 !== m_into2 || rd_cnt2 !== exp_rd(3)) begin
        n_fail++; $display("FAIL rand_3ch i=%0d: got run=%b pend=%b int_o=%b cnt=%0d want %b %b %b %0d", i, run2, pend2, int_o2, rd_cnt2, m_run[2:0], m_pend[2:0], m_into2, exp_rd(3));
      end
    end
`ifdef HY_TIMER_PRESCALE_EN
    prescale = '0;
`endif
  endtask

`ifdef HY_TIMER_PRESCALE_EN
  task automatic test_prescale();
    prescale = 8'd2;
    do_reset();
    int_mask = 4'b0001; rd_ch = 0;
    set_cfg(0, 1, 1'b1, 1'b1);
    cycle();
    for (int e = 1; e <= 36; e++) begin
      int_clr[0] = 1'b1;
      cycle();
      n_checks++;
      if (int_pend[0] !== (e % 6 == 5) || int_pend !== m_pend) begin
        n_fail++; $display("FAIL prescale_event e=%0d: got pend=%b want %b", e, int_pend[0], e % 6 == 5);
      end
    end
    prescale = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_periodic();
    test_one_shot();
    test_all_channels();
    test_stop();
    test_contention();
    test_out_of_range();
    test_random();
`ifdef HY_TIMER_PRESCALE_EN
    test_prescale();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
